// File: rtl/rot_share_pkg.sv
// Shared types and helpers for the rotator-sharing controller: direction encoding,
// right-to-left amount folding and the round-robin pick.
package rot_share_pkg;

  localparam int unsigned MAX_REQ = 16;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // A right rotate by k equals a left rotate by (2**n - k) mod 2**n.
  function automatic int unsigned eff_amt(input int unsigned amt, input dir_e dir,
                                          input int unsigned n);
    int unsigned w;
    w = 32'd1 << n;
    if (dir == DIR_RIGHT) begin
      return (w - (amt % w)) % w;
    end else begin
      return amt % w;
    end
  endfunction

  // First valid index found scanning upward from ptr, wrapping at nreq.
  function automatic logic [3:0] rr_pick(input logic [15:0] valid, input logic [3:0] ptr,
                                         input int unsigned nreq);
    logic [3:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = 4'd0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % nreq;
      if (!found && (k < nreq) && valid[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rot_share_ctrl_if.sv
// Requester-side and result-side handshake bundle of rot_share_ctrl.
interface rot_share_ctrl_if #(
  parameter int N    = 3,
  parameter int NREQ = 4
);
  localparam int W  = 2 ** N;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ*N-1:0] req_amt;
  logic [NREQ-1:0]   req_dir;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [IW-1:0]     out_id;
  logic [1:0]        inflight;

  modport master (
    output req_valid, req_data, req_amt, req_dir, out_ready,
    input  req_ready, out_valid, out_data, out_id, inflight
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_dir, out_ready,
    output req_ready, out_valid, out_data, out_id, inflight
  );

endinterface

// File: rtl/rot_share_ctrl_chk.sv
// Protocol properties of the result port and the grant vector.
module rot_share_ctrl_chk #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IW   = 2
) (
  input logic            clk,
  input logic            reset,
  input logic [NREQ-1:0] req_ready,
  input logic            out_valid,
  input logic            out_ready,
  input logic [W-1:0]    out_data,
  input logic [IW-1:0]   out_id
);

  a_ready_onehot0: assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready));

  a_out_hold: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_id)));

endmodule

// File: rtl/rot_share_ctrl_shifter.sv
// Shared combinational left rotator on 2**N-bit words; out bit (j+k) mod W takes in bit j.
module param_left_shifter #(
  parameter int N = 3
) (
  input  logic [2**N-1:0] data_in,
  input  logic [N-1:0]    amt,
  output logic [2**N-1:0] data_out
);
  localparam int W = 2 ** N;

  logic [W-1:0] stage_s;

  // Log-depth barrel: stage s rotates left by 2**s when amt[s] is set.
  always_comb begin
    stage_s = data_in;
    for (int s = 0; s < N; s++) begin
      if (amt[s]) begin
        stage_s = (stage_s << (2 ** s)) | (stage_s >> (W - (2 ** s)));
      end else begin
        stage_s = stage_s;
      end
    end
    data_out = stage_s;
  end

endmodule

// File: rtl/rot_share_ctrl.sv
// Round-robin arbiter and two-stage pipeline (issue register A, output register B)
// sharing one left rotator among NREQ requesters; right rotates are folded before issue.
module rot_share_ctrl
  import rot_share_pkg::*;
#(
  parameter int N    = 3,
  parameter int NREQ = 4
) (
  input logic             clk,
  input logic             reset,
  rot_share_ctrl_if.slave bus
);
  localparam int W  = 2 ** N;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic          a_valid_r;
  logic [W-1:0]  a_data_r;
  logic [N-1:0]  a_amt_r;
  logic [IW-1:0] a_id_r;
  logic          out_valid_r;
  logic [W-1:0]  out_data_r;
  logic [IW-1:0] out_id_r;
  logic [IW-1:0] ptr_r;
  logic [1:0]    inflight_r;

  logic            any_valid_s;
  logic            b_load_s;
  logic            a_load_s;
  logic            xfer_s;
  logic            a_valid_nxt_s;
  logic            out_valid_nxt_s;
  logic [3:0]      pick_s;
  logic [IW-1:0]   g_s;
  logic [IW-1:0]   ptr_nxt_s;
  logic [NREQ-1:0] ready_s;
  logic [W-1:0]    sel_data_s;
  logic [N-1:0]    sel_amt_s;
  logic            sel_dir_s;
  logic [31:0]     eff_full_s;
  logic [N-1:0]    eff_s;
  logic [W-1:0]    rot_s;

  // Grant selection and pipeline advance decisions.
  always_comb begin
    b_load_s    = a_valid_r && (!out_valid_r || bus.out_ready);
    a_load_s    = !a_valid_r || b_load_s;
    any_valid_s = |bus.req_valid;
    pick_s      = rr_pick(16'(bus.req_valid), 4'(ptr_r), NREQ);
    g_s         = pick_s[IW-1:0];
    xfer_s      = any_valid_s && a_load_s && !reset;
    ready_s     = '0;
    if (xfer_s) begin
      ready_s[g_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
    if (32'(g_s) == NREQ - 1) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = g_s + IW'(1);
    end
    a_valid_nxt_s   = a_load_s ? xfer_s : a_valid_r;
    out_valid_nxt_s = b_load_s ? 1'b1 : (out_valid_r && !bus.out_ready);
  end

  // Payload of the granted requester, with the direction folded into a left amount.
  always_comb begin
    sel_data_s = bus.req_data[32'(g_s) * W +: W];
    sel_amt_s  = bus.req_amt[32'(g_s) * N +: N];
    sel_dir_s  = bus.req_dir[g_s];
    eff_full_s = eff_amt(32'(sel_amt_s), dir_e'(sel_dir_s), N);
    eff_s      = eff_full_s[N-1:0];
  end

  param_left_shifter #(.N(N)) u_rot (
    .data_in  (a_data_r),
    .amt      (a_amt_r),
    .data_out (rot_s)
  );

  // Stage A: issue register, refilled whenever it is empty or moving into B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid_r <= 1'b0;
      a_data_r  <= '0;
      a_amt_r   <= '0;
      a_id_r    <= '0;
    end else if (a_load_s) begin
      a_valid_r <= xfer_s;
      if (xfer_s) begin
        a_data_r <= sel_data_s;
        a_amt_r  <= eff_s;
        a_id_r   <= g_s;
      end
    end
  end

  // Stage B: output register; holds its contents while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_id_r    <= '0;
    end else if (b_load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= rot_s;
      out_id_r    <= a_id_r;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Round-robin pointer and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r      <= '0;
      inflight_r <= 2'd0;
    end else begin
      if (xfer_s) begin
        ptr_r <= ptr_nxt_s;
      end
      inflight_r <= {1'b0, a_valid_nxt_s} + {1'b0, out_valid_nxt_s};
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_id    = out_id_r;
  assign bus.inflight  = inflight_r;

  rot_share_ctrl_chk #(.NREQ(NREQ), .W(W), .IW(IW)) u_chk (
    .clk       (clk),
    .reset     (reset),
    .req_ready (ready_s),
    .out_valid (out_valid_r),
    .out_ready (bus.out_ready),
    .out_data  (out_data_r),
    .out_id    (out_id_r)
  );

endmodule

// File: tb/tb_rot_share_ctrl.sv
// Randomized and directed bench for rot_share_ctrl against a queue-based model of the result stream.
module tb_rot_share_ctrl;
  localparam int N    = 3;
  localparam int NREQ = 4;
  localparam int W    = 8;

  typedef struct {
    logic [W-1:0] data;
    int           id;
    bit           vis;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rot_share_ctrl_if #(.N(N), .NREQ(NREQ)) bus ();
  rot_share_ctrl #(.N(N), .NREQ(NREQ)) dut (.clk(clk), .reset(reset), .bus(bus));

  int           n_checks = 0;
  int           n_pass   = 0;
  ent_t         q[$];
  int           ptr      = 0;
  int           cur_g    = -1;
  bit           cur_rdy  = 1'b0;
  bit           last_xfer;
  int           last_g;
  int           mode     = 0;
  int           obs_ids[$];
  bit           v_valid[NREQ];
  logic [W-1:0] v_data[NREQ];
  logic [N-1:0] v_amt[NREQ];
  logic         v_dir[NREQ];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] d, input int k);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < W; j++) r[(j + k) % W] = d[j];
    return r;
  endfunction

  function automatic int grant_of(input int p);
    for (int k = 0; k < NREQ; k++)
      if (v_valid[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]         = v_valid[i];
      bus.req_data[i*W +: W]   = v_data[i];
      bus.req_amt[i*N +: N]    = v_amt[i];
      bus.req_dir[i]           = v_dir[i];
    end
  endtask

  task automatic new_payload(input int i);
    v_data[i] = 8'($urandom);
    v_amt[i]  = 3'($urandom);
    v_dir[i]  = 1'($urandom);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] d, input logic [N-1:0] a, input logic dr);
    v_valid[i] = 1'b1;
    v_data[i]  = d;
    v_amt[i]   = a;
    v_dir[i]   = dr;
  endtask

  // Compare DUT outputs with the model before the coming edge.
  task automatic compare();
    logic [NREQ-1:0] exp_rdy;
    bit ev;
    cur_g   = grant_of(ptr);
    cur_rdy = (q.size() < 2) || bus.out_ready;
    exp_rdy = '0;
    if (cur_g >= 0 && cur_rdy) exp_rdy[cur_g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    ev = (q.size() > 0) && q[0].vis;
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    if (ev) begin
      chk("out_data", 64'(bus.out_data), 64'(q[0].data));
      chk("out_id", 64'(bus.out_id), 64'(q[0].id));
    end
    chk("inflight", 64'(bus.inflight), 64'(q.size()));
    if (bus.out_valid && bus.out_ready) obs_ids.push_back(int'(bus.out_id));
  endtask

  task automatic model_update();
    int e;
    if (q.size() > 0 && q[0].vis && bus.out_ready) void'(q.pop_front());
    if (q.size() > 0) q[0].vis = 1'b1;
    last_xfer = (cur_g >= 0) && cur_rdy;
    last_g    = cur_g;
    if (last_xfer) begin
      e = v_dir[cur_g] ? (W - int'(v_amt[cur_g])) % W : int'(v_amt[cur_g]);
      q.push_back('{data: rotl(v_data[cur_g], e), id: cur_g, vis: 1'b0});
      ptr = (cur_g + 1) % NREQ;
    end
  endtask

  task automatic refill();
    for (int i = 0; i < NREQ; i++) begin
      if (last_xfer && last_g == i) begin
        if (mode == 0) v_valid[i] = 1'b0;
        else if (mode == 2) v_valid[i] = 1'($urandom_range(0, 1));
        new_payload(i);
      end else if (mode == 2 && !v_valid[i]) begin
        v_valid[i] = ($urandom_range(0, 2) == 0);
        new_payload(i);
      end
    end
    if (mode == 2) bus.out_ready = ($urandom_range(0, 3) != 0);
    drive();
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
    refill();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst inflight", 64'(bus.inflight), 64'd0);
    chk("rst out_data", 64'(bus.out_data), 64'd0);
    chk("rst out_id", 64'(bus.out_id), 64'd0);
    chk("rst req_ready", 64'(bus.req_ready), 64'd0);
    q.delete();
    ptr = 0;
    for (int i = 0; i < NREQ; i++) v_valid[i] = 1'b0;
    drive();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic single(input int i, input logic [W-1:0] d, input logic [N-1:0] a,
                        input logic dr, input logic [W-1:0] exp);
    mode          = 0;
    bus.out_ready = 1'b1;
    set_req(i, d, a, dr);
    drive();
    cycle();
    chk("single early", 64'(bus.out_valid), 64'd0);
    cycle();
    chk("single valid", 64'(bus.out_valid), 64'd1);
    chk("single data", 64'(bus.out_data), 64'(exp));
    chk("single id", 64'(bus.out_id), 64'(i));
    cycle();
  endtask

  initial begin
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      v_valid[i] = 1'b0;
      new_payload(i);
    end
    drive();
    #2;
    do_reset();

    single(0, 8'h01, 3'd3, 1'b0, 8'h08);
    single(0, 8'h81, 3'd1, 1'b1, 8'hC0);
    single(2, 8'h81, 3'd0, 1'b1, 8'h81);

    // Full round robin with every requester streaming.
    do_reset();
    mode          = 1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      v_valid[i] = 1'b1;
      new_payload(i);
    end
    drive();
    obs_ids.delete();
    repeat (12) cycle();
    chk("rr count", 64'(obs_ids.size()), 64'd10);
    for (int k = 0; k < 8 && k < obs_ids.size(); k++) chk("rr order", 64'(obs_ids[k]), 64'(k % 4));

    // Backpressure with three queued requests.
    do_reset();
    mode          = 0;
    bus.out_ready = 1'b0;
    set_req(0, 8'h01, 3'd1, 1'b0);
    set_req(1, 8'h10, 3'd2, 1'b0);
    set_req(2, 8'h03, 3'd1, 1'b1);
    drive();
    repeat (2) cycle();
    repeat (5) begin
      cycle();
      chk("bp inflight", 64'(bus.inflight), 64'd2);
      chk("bp req_ready", 64'(bus.req_ready), 64'd0);
      chk("bp out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp out_data", 64'(bus.out_data), 64'h02);
    end
    bus.out_ready = 1'b1;
    obs_ids.delete();
    repeat (5) cycle();
    chk("bp count", 64'(obs_ids.size()), 64'd3);
    for (int k = 0; k < 3 && k < obs_ids.size(); k++) chk("bp order", 64'(obs_ids[k]), 64'(k));

    // Skewed fairness starting from ptr 2.
    do_reset();
    mode          = 0;
    bus.out_ready = 1'b1;
    set_req(1, 8'h5A, 3'd2, 1'b0);
    drive();
    repeat (3) cycle();
    mode = 1;
    set_req(1, 8'h11, 3'd1, 1'b0);
    set_req(3, 8'h22, 3'd1, 1'b1);
    drive();
    obs_ids.delete();
    repeat (6) cycle();
    chk("skew count", 64'(obs_ids.size()), 64'd4);
    for (int k = 0; k < 4 && k < obs_ids.size(); k++)
      chk("skew order", 64'(obs_ids[k]), (k % 2 == 0) ? 64'd3 : 64'd1);

    // Reset with both stages occupied.
    mode          = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 3'd1, 1'b0);
    drive();
    repeat (3) cycle();
    chk("pre-rst inflight", 64'(bus.inflight), 64'd2);
    do_reset();
    bus.out_ready = 1'b1;
    set_req(3, 8'hF0, 3'd4, 1'b0);
    set_req(2, 8'h0F, 3'd4, 1'b1);
    drive();
    obs_ids.delete();
    repeat (4) cycle();
    chk("post-rst count", 64'(obs_ids.size()), 64'd2);
    if (obs_ids.size() > 0) chk("post-rst first", 64'(obs_ids[0]), 64'd2);

    // Random traffic.
    do_reset();
    mode = 2;
    repeat (3000) cycle();
    mode = 0;
    for (int i = 0; i < NREQ; i++) v_valid[i] = 1'b0;
    bus.out_ready = 1'b1;
    drive();
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
